// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_scan_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    DRIVE = 2'd2
  } state_e;

  // Segment patterns ordered {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_seg_dec.sv
// BCD nibble to 7-segment pattern; codes 10..15 give a blank display.
// Latency: purely combinational.
// Backpressure: none.
module bcd_seg_dec
  import bcd_scan_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  // Table lookup; anything outside 0..9 is treated as blank.
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Scans NUM_DIGITS 7-segment digits (gap + drive per slot); BCD_LZB_EN adds leading-zero blanking.
// Latency: outputs registered; first frame starts one cycle after en rises, frame = NUM_DIGITS*PRESCALE.
// Backpressure: upd_ready low while an accepted update waits for the next frame boundary.
module bcd_scan_ctrl
  import bcd_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]                  seg,
  output logic [NUM_DIGITS-1:0]       dig_sel,
  output logic                        frame_tick
);

  localparam int DW = BCD_W * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PRESCALE - 2);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     active_q, active_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic              pend_q, pend_d;
  logic [6:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic              tick_q, tick_d;
  logic [BCD_W-1:0]  cur_bcd;
  logic [6:0]        dec_seg;
  logic              lead_blank;
  logic              commit;
  logic              capture;

  // Scan sequencing: next state, digit index and slot counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GAP;
          idx_d   = '0;
          tick_d  = 1'b1;
        end
        GAP: begin
          state_d = DRIVE;
          cnt_d   = CNT_LOAD;
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            if (idx_q == LAST_IDX) begin
              idx_d  = '0;
              tick_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Update handshake: commit only when idle or entering a new frame, using the old pending flag.
  always_comb begin
    commit   = pend_q & ((state_q == IDLE) | tick_d);
    capture  = upd_valid & ~pend_q;
    active_d = commit ? shadow_q : active_q;
    shadow_d = capture ? bcd_in : shadow_q;
    pend_d   = capture | (pend_q & ~commit);
  end

  assign cur_bcd = active_q[BCD_W*int'(idx_d) +: BCD_W];

  bcd_seg_dec u_dec (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

`ifdef BCD_LZB_EN
  // A digit above digit 0 is blank when it and every higher digit are zero.
  always_comb begin
    lead_blank = (idx_d != '0) && ((active_q >> (BCD_W*int'(idx_d))) == '0);
  end
`else
  assign lead_blank = 1'b0;
`endif

  // Output values for the state being entered, so seg and dig_sel move together.
  always_comb begin
    seg_d = SEG_BLANK;
    sel_d = '0;
    if (state_d == DRIVE) begin
      sel_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
      seg_d = lead_blank ? SEG_BLANK : dec_seg;
    end
  end

  // All state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      seg_q    <= SEG_BLANK;
      sel_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      tick_q   <= tick_d;
    end
  end

  assign upd_ready  = ~pend_q;
  assign seg        = seg_q;
  assign dig_sel    = sel_q;
  assign frame_tick = tick_q;

endmodule
